// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access sequencer.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_XFER  = 3'd1,
        ST_PTR_XFER = 3'd2,
        ST_PTR_GAP  = 3'd3,
        ST_RD_XFER  = 3'd4,
        ST_GAP      = 3'd5,
        ST_RESP     = 3'd6
    } i2c_ctrl_state_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    // Number of ACK windows that complete each transaction type
    localparam logic [1:0] WR_EDGES  = 2'd3;
    localparam logic [1:0] PTR_EDGES = 2'd2;
    localparam logic [1:0] RD_EDGES  = 2'd2;

endpackage

// File: rtl/i2c_reg_ctrl_if.sv
// Command/response handshake bundle between a requester and i2c_reg_ctrl.
interface i2c_reg_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/i2c_gap_timer.sv
// Loadable saturating down-counter; done is high whenever the count is zero.
module i2c_gap_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Single-register read/write sequencer driving a byte-level I2C master.
// Reads are a pointer write, STOP, gap, then a read transaction.
module i2c_reg_ctrl
    import i2c_pkg::*;
#(
    parameter int GAP_CYCLES     = 2000,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter bit MSB_FIRST      = 1'b1
) (
    input  logic           clk,
    input  logic           arstn,
    i2c_reg_ctrl_if.slave  bus,
    output logic           m_ena,
    output logic [7:0]     m_byte,
    output logic [7:0]     m_addr_rw,
    output logic           m_msb_lsb,
    input  logic           m_end_trans,
    input  logic [7:0]     m_byte_rcv
);

    localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYCLES);

    i2c_ctrl_state_t state, state_nxt;

    logic       end_q;
    logic       rise;
    logic [1:0] edge_cnt, edge_cnt_nxt, edge_inc;
    logic [6:0] cap_dev, cap_dev_nxt;
    logic [7:0] cap_wdata, cap_wdata_nxt;
    logic       m_ena_nxt;
    logic [7:0] m_byte_nxt, m_addr_rw_nxt;
    logic [7:0] rdata, rdata_nxt;
    logic       err, err_nxt;
    logic       accept, rsp_done, is_xfer;

    logic             tmr_load, tmr_dec, tmr_done;
    logic [CNT_W-1:0] tmr_val;

    assign rise     = m_end_trans & ~end_q;
    assign edge_inc = (edge_cnt == 2'd3) ? edge_cnt : edge_cnt + 2'd1;
    assign accept   = bus.cmd_valid & bus.cmd_ready;
    assign rsp_done = bus.rsp_valid & bus.rsp_ready;
    assign is_xfer  = (state == ST_WR_XFER) || (state == ST_PTR_XFER) || (state == ST_RD_XFER);

    assign m_msb_lsb     = MSB_FIRST;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;

    // Gap and timeout never overlap, so one timer serves both
    i2c_gap_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .arstn    (arstn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state         <= ST_IDLE;
            end_q         <= 1'b0;
            edge_cnt      <= 2'd0;
            cap_dev       <= 7'd0;
            cap_wdata     <= 8'd0;
            m_ena         <= 1'b0;
            m_byte        <= 8'd0;
            m_addr_rw     <= 8'd0;
            rdata         <= 8'd0;
            err           <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            end_q         <= m_end_trans;
            edge_cnt      <= edge_cnt_nxt;
            cap_dev       <= cap_dev_nxt;
            cap_wdata     <= cap_wdata_nxt;
            m_ena         <= m_ena_nxt;
            m_byte        <= m_byte_nxt;
            m_addr_rw     <= m_addr_rw_nxt;
            rdata         <= rdata_nxt;
            err           <= err_nxt;
            bus.cmd_ready <= (state_nxt == ST_IDLE);
            bus.rsp_valid <= (state_nxt == ST_RESP);
        end
    end

    // A rise on the same cycle as timer expiry always takes precedence
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = (bus.cmd_rw == RW_READ) ? ST_PTR_XFER : ST_WR_XFER;
            end
            ST_WR_XFER: begin
                if (rise) begin
                    if (edge_inc == WR_EDGES) state_nxt = ST_GAP;
                end else if (tmr_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_PTR_XFER: begin
                if (rise) begin
                    if (edge_inc == PTR_EDGES) state_nxt = ST_PTR_GAP;
                end else if (tmr_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_PTR_GAP: begin
                if (!m_end_trans && tmr_done) state_nxt = ST_RD_XFER;
            end
            ST_RD_XFER: begin
                if (rise) begin
                    if (edge_inc == RD_EDGES) state_nxt = ST_GAP;
                end else if (tmr_done) begin
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (!m_end_trans && tmr_done) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        edge_cnt_nxt  = rise ? edge_inc : edge_cnt;
        cap_dev_nxt   = cap_dev;
        cap_wdata_nxt = cap_wdata;
        m_ena_nxt     = m_ena;
        m_byte_nxt    = m_byte;
        m_addr_rw_nxt = m_addr_rw;
        rdata_nxt     = rdata;
        err_nxt       = err;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;
        tmr_val       = GAP_LOAD;

        if (state == ST_IDLE) begin
            if (accept) begin
                cap_dev_nxt   = bus.cmd_dev;
                cap_wdata_nxt = bus.cmd_wdata;
                m_ena_nxt     = 1'b1;
                m_addr_rw_nxt = {bus.cmd_dev, RW_WRITE};
                m_byte_nxt    = bus.cmd_reg;
                edge_cnt_nxt  = 2'd0;
                rdata_nxt     = 8'd0;
                err_nxt       = 1'b0;
                tmr_load      = 1'b1;
                tmr_val       = TO_LOAD;
            end
        end else if (is_xfer) begin
            tmr_dec = 1'b1;
            if (state_nxt != state) begin
                // Dropping m_ena inside the ACK window makes the master STOP
                m_ena_nxt = 1'b0;
                tmr_load  = 1'b1;
                tmr_val   = GAP_LOAD;
                if (!rise) begin
                    err_nxt   = 1'b1;
                    rdata_nxt = 8'd0;
                end else if (state == ST_RD_XFER) begin
                    rdata_nxt = m_byte_rcv;
                end
            end else if (rise) begin
                tmr_load = 1'b1;
                tmr_val  = TO_LOAD;
                if ((state == ST_WR_XFER) && (edge_inc == WR_EDGES - 2'd1)) m_byte_nxt = cap_wdata;
            end
        end else if ((state == ST_PTR_GAP) || (state == ST_GAP)) begin
            if (m_end_trans) begin
                tmr_load = 1'b1;
                tmr_val  = GAP_LOAD;
            end else if (tmr_done && (state == ST_PTR_GAP)) begin
                m_ena_nxt     = 1'b1;
                m_addr_rw_nxt = {cap_dev, RW_READ};
                edge_cnt_nxt  = 2'd0;
                tmr_load      = 1'b1;
                tmr_val       = TO_LOAD;
            end else begin
                tmr_dec = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: behavioural byte-level master model plus response scoreboard.
module tb_i2c_reg_ctrl;

    localparam int GAP      = 20;
    localparam int TMO      = 200;
    localparam int BYTE_CYC = 9;
    localparam int ACK_CYC  = 4;
    localparam int LIMIT    = 5000;

    logic       clk = 1'b0;
    logic       arstn;
    logic       m_ena;
    logic [7:0] m_byte;
    logic [7:0] m_addr_rw;
    logic       m_msb_lsb;
    logic       m_end_trans;
    logic [7:0] m_byte_rcv;

    i2c_reg_ctrl_if bus();

    i2c_reg_ctrl #(
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO),
        .MSB_FIRST      (1'b1)
    ) dut (
        .clk         (clk),
        .arstn       (arstn),
        .bus         (bus.slave),
        .m_ena       (m_ena),
        .m_byte      (m_byte),
        .m_addr_rw   (m_addr_rw),
        .m_msb_lsb   (m_msb_lsb),
        .m_end_trans (m_end_trans),
        .m_byte_rcv  (m_byte_rcv)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         rsp_cyc = 0;
    int         rise_cnt = 0;
    int         low_run = 0;
    int         last_gap = 0;
    bit         nack_mode = 1'b0;
    bit         busy = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic [8:0] exp_q[$];
    logic [7:0] addr_log[$];
    logic [7:0] byte_log[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: address byte, then data bytes until m_ena is low at the end of an ACK window
    initial begin
        m_end_trans = 1'b0;
        m_byte_rcv  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (m_ena && !nack_mode) begin
                bit is_rd;
                busy  = 1'b1;
                is_rd = m_addr_rw[0];
                addr_log.push_back(m_addr_rw);
                for (int k = 0; k < 8; k++) begin
                    if (k > 0 && !is_rd) byte_log.push_back(m_byte);
                    repeat (BYTE_CYC) @(posedge clk);
                    #1;
                    m_end_trans = 1'b1;
                    m_byte_rcv  = (is_rd && k > 0) ? rd_data : 8'h00;
                    repeat (ACK_CYC) @(posedge clk);
                    #1;
                    m_end_trans = 1'b0;
                    m_byte_rcv  = 8'h00;
                    if (!m_ena) break;
                end
                busy = 1'b0;
            end
        end
    end

    // Monitors: rise count, m_ena low-run length, response scoreboard
    initial begin
        bit prev_end = 1'b0;
        bit prev_ena = 1'b0;
        forever begin
            @(negedge clk);
            if (m_end_trans && !prev_end) rise_cnt++;
            prev_end = m_end_trans;
            if (!m_ena) begin
                low_run++;
            end else begin
                if (!prev_ena) last_gap = low_run;
                low_run = 0;
            end
            prev_ena = m_ena;
            if (arstn && bus.rsp_valid && bus.rsp_ready) begin
                rsp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", {bus.rsp_err, bus.rsp_rdata}, 9'h1FF);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check_eq("rsp_err", bus.rsp_err, e[8]);
                    check_eq("rsp_rdata", bus.rsp_rdata, e[7:0]);
                end
            end
        end
    end

    task automatic wait_accept(input string tag);
        bit got = 1'b0;
        for (int n = 0; n < LIMIT && !got; n++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                got = 1'b1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        check_eq(tag, got, 1'b1);
    endtask

    task automatic send_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd, input logic e_err, input logic [7:0] e_rd);
        exp_q.push_back({e_err, e_rd});
        bus.cmd_rw    = rw;
        bus.cmd_dev   = dev;
        bus.cmd_reg   = rg;
        bus.cmd_wdata = wd;
        bus.cmd_valid = 1'b1;
        wait_accept("cmd_accept");
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag);
        for (int n = 0; n < LIMIT && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        check_eq(tag, exp_q.size(), 0);
    endtask

    task automatic wait_model_idle();
        for (int n = 0; n < LIMIT && busy; n++) @(posedge clk);
        #1;
        check_eq("model_idle", busy, 1'b0);
    endtask

    task automatic clear_logs();
        addr_log.delete();
        byte_log.delete();
    endtask

    initial begin
        int base;
        int bad;
        logic [7:0] snap_rd;
        logic       snap_err;

        arstn         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_dev   = 7'h00;
        bus.cmd_reg   = 8'h00;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 8'h00);
        check_eq("rst_rsp_err", bus.rsp_err, 1'b0);
        check_eq("rst_m_ena", m_ena, 1'b0);
        check_eq("rst_m_byte", m_byte, 8'h00);
        check_eq("rst_m_addr_rw", m_addr_rw, 8'h00);
        check_eq("rst_m_msb_lsb", m_msb_lsb, 1'b1);
        arstn = 1'b1;
        @(posedge clk); #1;
        check_eq("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

        // Plain write
        clear_logs();
        base = rise_cnt;
        send_cmd(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0, 8'h00);
        wait_rsp("wr_rsp");
        check_eq("wr_naddr", addr_log.size(), 1);
        if (addr_log.size() >= 1) check_eq("wr_addr", addr_log[0], 8'hA0);
        check_eq("wr_nbytes", byte_log.size(), 2);
        if (byte_log.size() >= 2) begin
            check_eq("wr_byte0", byte_log[0], 8'h10);
            check_eq("wr_byte1", byte_log[1], 8'hA5);
        end
        check_eq("wr_rises", rise_cnt - base, 3);

        // Random-access read
        wait_model_idle();
        clear_logs();
        base    = rise_cnt;
        rd_data = 8'h3C;
        send_cmd(1'b1, 7'h50, 8'h22, 8'hFF, 1'b0, 8'h3C);
        wait_rsp("rd_rsp");
        check_eq("rd_naddr", addr_log.size(), 2);
        if (addr_log.size() >= 2) begin
            check_eq("rd_ptr_addr", addr_log[0], 8'hA0);
            check_eq("rd_rd_addr", addr_log[1], 8'hA1);
        end
        check_eq("rd_nbytes", byte_log.size(), 1);
        if (byte_log.size() >= 1) check_eq("rd_ptr_byte", byte_log[0], 8'h22);
        check_eq("rd_rises", rise_cnt - base, 4);
        check_eq("rd_gap_ok", last_gap >= GAP, 1'b1);

        // Address NACK: master never opens an ACK window
        wait_model_idle();
        nack_mode = 1'b1;
        send_cmd(1'b0, 7'h50, 8'h10, 8'h01, 1'b1, 8'h00);
        wait_rsp("nack_rsp");
        check_eq("nack_duration", (rsp_cyc - acc_cyc) >= TMO, 1'b1);
        check_eq("nack_m_ena", m_ena, 1'b0);
        nack_mode = 1'b0;
        clear_logs();
        send_cmd(1'b0, 7'h50, 8'h11, 8'h02, 1'b0, 8'h00);
        wait_rsp("post_nack_rsp");
        check_eq("post_nack_nbytes", byte_log.size(), 2);

        // Response back-pressure
        wait_model_idle();
        bus.rsp_ready = 1'b0;
        rd_data = 8'h99;
        send_cmd(1'b1, 7'h50, 8'h33, 8'h00, 1'b0, 8'h99);
        for (int n = 0; n < LIMIT && !bus.rsp_valid; n++) @(posedge clk);
        #1;
        check_eq("hold_rsp_valid", bus.rsp_valid, 1'b1);
        snap_rd  = bus.rsp_rdata;
        snap_err = bus.rsp_err;
        base = addr_log.size();
        bad  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== snap_rd || bus.rsp_err !== snap_err ||
                bus.cmd_ready !== 1'b0 || m_ena !== 1'b0) bad++;
            @(posedge clk); #1;
            bus.cmd_valid = (i == 50);
            bus.cmd_rw    = 1'b0;
            bus.cmd_reg   = 8'h77;
        end
        bus.cmd_valid = 1'b0;
        check_eq("hold_stable", bad, 0);
        bus.rsp_ready = 1'b1;
        wait_rsp("hold_rsp");
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_no_accept_ena", m_ena, 1'b0);
        check_eq("hold_no_accept_addr", addr_log.size(), base);

        // Reset in the middle of a write
        wait_model_idle();
        base = rise_cnt;
        send_cmd(1'b0, 7'h50, 8'h10, 8'h77, 1'b0, 8'h00);
        for (int n = 0; n < LIMIT && rise_cnt < base + 1; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b0;
        exp_q.delete();
        #1;
        check_eq("arst_m_ena", m_ena, 1'b0);
        check_eq("arst_rsp_valid", bus.rsp_valid, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        arstn = 1'b1;
        @(posedge clk); #1;
        check_eq("arst_cmd_ready", bus.cmd_ready, 1'b1);
        wait_model_idle();
        clear_logs();
        send_cmd(1'b0, 7'h51, 8'h01, 8'h5A, 1'b0, 8'h00);
        wait_rsp("arst_wr_rsp");
        if (addr_log.size() >= 1) check_eq("arst_wr_addr", addr_log[0], 8'hA2);
        check_eq("arst_wr_nbytes", byte_log.size(), 2);
        if (byte_log.size() >= 2) check_eq("arst_wr_byte1", byte_log[1], 8'h5A);

        // Back-to-back with cmd_valid held
        wait_model_idle();
        clear_logs();
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h000);
        bus.cmd_rw    = 1'b0;
        bus.cmd_dev   = 7'h50;
        bus.cmd_reg   = 8'h40;
        bus.cmd_wdata = 8'h11;
        bus.cmd_valid = 1'b1;
        wait_accept("b2b_acc_a");
        bus.cmd_reg   = 8'h41;
        bus.cmd_wdata = 8'h22;
        wait_accept("b2b_acc_b");
        bus.cmd_valid = 1'b0;
        check_eq("b2b_accept_cycle", acc_cyc - rsp_cyc, 1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("b2b_gap_ok", last_gap >= GAP, 1'b1);
        wait_rsp("b2b_rsp");
        check_eq("b2b_nbytes", byte_log.size(), 4);
        if (byte_log.size() >= 4) begin
            check_eq("b2b_byte0", byte_log[0], 8'h40);
            check_eq("b2b_byte1", byte_log[1], 8'h11);
            check_eq("b2b_byte2", byte_log[2], 8'h41);
            check_eq("b2b_byte3", byte_log[3], 8'h22);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/i2c_reg_ctrl.md
Name: i2c_reg_ctrl

Overview:
- Register-access sequencer that sits directly upstream of the team's byte-level I2C master.
- Accepts single-register read/write commands over a valid/ready interface and drives the master's enable, byte and address/RW inputs.
- Counts the master's per-byte ACK windows to step through the transfer and returns read data or an error on a response channel.
- Random-access reads are done as two transactions: a pointer write, then a STOP, then a read. The master has no repeated-start.

Parameters:
- GAP_CYCLES, 2000, clk cycles held idle after m_ena drops so the master completes STOP and returns to idle.
- TIMEOUT_CYCLES, 50000, max clk cycles between m_end_trans rising edges before the transfer is declared failed (NACK or stall).
- MSB_FIRST, 1, drives m_msb_lsb constantly (1 = MSB first).

Ports:
- clk  in  1  clock
- arstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_rw  in  1  0 = write, 1 = read
- cmd_dev  in  7  7-bit slave address
- cmd_reg  in  8  register address
- cmd_wdata  in  8  write data (ignored on read)
- rsp_valid  out  1  response present; held until rsp_ready
- rsp_ready  in  1  response accepted
- rsp_rdata  out  8  read data (0 on write or error)
- rsp_err  out  1  timeout/NACK occurred
- m_ena  out  1  to master enable
- m_byte  out  8  to master byte to send
- m_addr_rw  out  8  to master {dev, rw}
- m_msb_lsb  out  1  to master bit order
- m_end_trans  in  1  from master; high for the whole ACK window of each byte
- m_byte_rcv  in  8  from master; received byte, valid while m_end_trans is high

Behaviour:
- Reset values: cmd_ready=0 (goes to 1 in the first cycle after reset), rsp_valid=0, rsp_rdata=0, rsp_err=0, m_ena=0, m_byte=0, m_addr_rw=0, m_msb_lsb=MSB_FIRST, all counters 0, state IDLE. Reset mid-transfer drops m_ena immediately and discards the command.
- Command capture: on cmd_valid & cmd_ready, all cmd_* fields are registered. The command is not re-sampled afterwards.
- Edge detect: rise = m_end_trans & ~m_end_trans_q, with m_end_trans_q a one-flop delay. Each rise increments edge_cnt (2 bits) and reloads the timeout counter.
- States: IDLE, WR_XFER, PTR_XFER, PTR_GAP, RD_XFER, GAP, RESP.
- IDLE: on accept, go to WR_XFER (cmd_rw=0) or PTR_XFER (cmd_rw=1). Set m_ena=1, m_addr_rw={dev,0}, m_byte=reg. Clear edge_cnt and the timeout counter.
- WR_XFER:
  - Rise #1 (address ACK): no change.
  - Rise #2 (register ACK): m_byte <= wdata.
  - Rise #3 (data ACK): m_ena <= 0, go to GAP with err=0.
- PTR_XFER:
  - Rise #1: no change.
  - Rise #2: m_ena <= 0, go to PTR_GAP.
- PTR_GAP: wait until m_end_trans=0, then GAP_CYCLES cycles. Then m_addr_rw={dev,1}, m_ena=1, clear edge_cnt, go to RD_XFER.
- RD_XFER:
  - Rise #1: no change.
  - Rise #2: rdata <= m_byte_rcv, m_ena <= 0, go to GAP.
- m_ena drop timing: m_ena deasserts on the cycle after the rise is detected, while m_end_trans is still high. This gives the master a STOP rather than another byte.
- Timeout: in any *_XFER state, TIMEOUT_CYCLES cycles without a rise force m_ena=0, err=1, rdata=0, and a transition to GAP.
- GAP: wait until m_end_trans=0, then GAP_CYCLES cycles, then go to RESP.
- RESP: rsp_valid=1 with rsp_rdata/rsp_err stable. On rsp_ready, return to IDLE with rsp_valid=0. Back-to-back: cmd_ready=1 in the cycle after the handshake.
- Simultaneous rise and timeout expiry: the rise wins.
- Counter widths: clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)+1). Counters saturate and never wrap.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum i2c_ctrl_state_t;
  - localparams RW_WRITE=0 and RW_READ=1;
  - edge-count constants WR_EDGES=3, PTR_EDGES=2, RD_EDGES=2.
- One natural sub-module: i2c_gap_timer. It is a loadable down-counter with a done flag, instanced once and shared by the gap and timeout functions, since they are never active together.

Test Plan:
- Write dev=0x50 reg=0x10 data=0xA5 with an ACKing slave model -> m_addr_rw=0xA0; bytes on the bus 0x10 then 0xA5; exactly 3 rises; rsp_valid with err=0, rdata=0.
- Read dev=0x50 reg=0x22, slave returns 0x3C -> pointer transaction sends 0x22, STOP, gap ≥ GAP_CYCLES, m_addr_rw=0xA1; rsp_rdata=0x3C, err=0.
- NACK on address (master never raises m_end_trans) -> after TIMEOUT_CYCLES, m_ena=0, rsp_err=1, rdata=0; the next command is accepted normally.
- Hold rsp_ready=0 for 100 cycles -> rsp_valid and data stay stable, cmd_ready stays 0; a cmd_valid pulse in that window is not accepted.
- Assert arstn low during WR_XFER after rise #1 -> m_ena=0 the same cycle, rsp_valid=0; after reset release, cmd_ready=1 and a new write completes.
- Two back-to-back commands with cmd_valid held -> second is accepted the cycle after the first rsp handshake; m_ena low for ≥ GAP_CYCLES between them.
